// File: rtl/mpc_pkg.sv
// Shared definitions for the multiphase model-predictive boost controller:
// FSM encoding, default Q16.16 constants and wide Q-format helpers.
package mpc_pkg;

    localparam int MPC_W       = 32;
    localparam int MPC_F       = 16;
    localparam int MPC_N_PHASE = 2;

    // Q16.16 defaults: Ts/L = 0.25, Iref start 4.0, step 0.5, ceiling 16.0
    localparam longint MPC_K_TS_L     = 64'sd16384;
    localparam longint MPC_IREF_INIT  = 64'sd262144;
    localparam longint MPC_IREF_DELTA = 64'sd32768;
    localparam longint MPC_IREF_MAX   = 64'sd1048576;

    // Wide working type: any W <= 64 operand, sum or full product fits.
    localparam int QW = 128;
    typedef logic signed [QW-1:0] qwide_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POWER  = 3'd1,
        MPPT   = 3'd2,
        MULA   = 3'd3,
        MULB   = 3'd4,
        EVAL   = 3'd5,
        UPDATE = 3'd6
    } mpc_state_t;

    // Clip a wide signed value to the signed range of a w-bit word.
    function automatic qwide_t q_sat(input qwide_t x, input int w);
        qwide_t hi;
        qwide_t lo;
        hi = (qwide_t'(1) <<< (w - 1)) - qwide_t'(1);
        lo = -(qwide_t'(1) <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // Magnitude of a w-bit value; the most-negative code maps to max positive.
    function automatic qwide_t q_abs(input qwide_t x, input int w);
        return q_sat((x < 0) ? -x : x, w);
    endfunction

endpackage

// File: rtl/mpc_sat_mul.sv
// Registered signed W x W multiplier: full 2W-bit product, realigned by F
// fraction bits and saturated back into the signed W-bit Q range.
module mpc_sat_mul
    import mpc_pkg::*;
#(
    parameter int W = MPC_W,
    parameter int F = MPC_F
) (
    input  logic                clk,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);

    logic signed [2*W-1:0] prod_full;
    logic signed [W-1:0]   prod_sat;
    logic signed [W-1:0]   prod_p0;

    assign prod_full = a * b;
    assign prod_sat  = W'(q_sat(qwide_t'(prod_full) >>> F, W));

    // Product register: one cycle from operands to result.
    always_ff @(posedge clk) begin
        prod_p0 <= prod_sat;
    end

    assign p = prod_p0;

endmodule

// File: rtl/mpc_multiphase.sv
// Multiphase interleaved boost controller. Each sample strobe runs one
// control step: PV power, P&O (or external) current reference, two predicted
// inductor-current increments, then a per-phase finite-control-set choice
// of the switch state that best tracks the per-phase reference.
module mpc_multiphase
    import mpc_pkg::*;
#(
    parameter int W       = MPC_W,
    parameter int F       = MPC_F,
    parameter int N_PHASE = MPC_N_PHASE,
    parameter logic signed [W-1:0] K_TS_L     = W'(MPC_K_TS_L),
    parameter logic signed [W-1:0] IREF_INIT  = W'(MPC_IREF_INIT),
    parameter logic signed [W-1:0] IREF_DELTA = W'(MPC_IREF_DELTA),
    parameter logic signed [W-1:0] IREF_MAX   = W'(MPC_IREF_MAX)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic signed [W-1:0]    i_Vpv,
    input  logic signed [W-1:0]    i_Ipv,
    input  logic signed [W-1:0]    i_Vout,
    input  logic [N_PHASE*W-1:0]   i_Iph,
    input  logic [N_PHASE-1:0]     i_ph_en,
    input  logic                   i_mode,
    input  logic signed [W-1:0]    i_Iref_ext,
    input  logic                   i_calc_DV,
    output logic [N_PHASE-1:0]     o_switch,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overrun,
    output logic signed [W-1:0]    o_Iref
);

    localparam int LOG2N = $clog2(N_PHASE);
    localparam int PW    = (N_PHASE > 1) ? LOG2N : 1;

    function automatic qwide_t ext(input logic signed [W-1:0] x);
        return qwide_t'(x);
    endfunction

    function automatic logic signed [W-1:0] sat_w(input qwide_t x);
        return W'(q_sat(x, W));
    endfunction

    function automatic logic signed [W-1:0] abs_w(input logic signed [W-1:0] x);
        return W'(q_abs(ext(x), W));
    endfunction

    function automatic logic signed [W-1:0] clamp_iref(input logic signed [W-1:0] x);
        if (x[W-1])
            return '0;
        else if (x > IREF_MAX)
            return IREF_MAX;
        else
            return x;
    endfunction

    // Sampled step inputs
    logic signed [W-1:0]  vpv_r;
    logic signed [W-1:0]  ipv_r;
    logic signed [W-1:0]  vout_r;
    logic signed [W-1:0]  iref_ext_r;
    logic [N_PHASE*W-1:0] iph_r;
    logic [N_PHASE-1:0]   ph_en_r;
    logic                 mode_r;

    // Controller state
    mpc_state_t           state;
    logic [PW-1:0]        ph_idx;
    logic signed [W-1:0]  iref;
    logic signed [W-1:0]  p_prev;
    logic                 dir_up;
    logic signed [W-1:0]  kv1;
    logic signed [W-1:0]  kv0;
    logic [N_PHASE-1:0]   sw_nxt;

    // Shared multiplier
    logic signed [W-1:0]  mul_a;
    logic signed [W-1:0]  mul_b;
    logic signed [W-1:0]  mul_p;

    // Step datapath
    logic signed [W-1:0]  vdiff;
    logic                 dir_next;
    logic signed [W-1:0]  iref_step;
    logic signed [W-1:0]  iref_mppt;
    logic signed [W-1:0]  iref_ph;
    logic signed [W-1:0]  iph_cur;
    logic signed [W-1:0]  pred1;
    logic signed [W-1:0]  pred0;
    logic signed [W-1:0]  e1;
    logic signed [W-1:0]  e0;
    logic                 sw_bit;

    mpc_sat_mul #(
        .W (W),
        .F (F)
    ) u_mul (
        .clk (i_clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    assign vdiff = sat_w(ext(vpv_r) - ext(vout_r));

    // Operands are issued one state ahead so each product lands in the state that consumes it.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            POWER: begin
                mul_a = vpv_r;
                mul_b = ipv_r;
            end
            MPPT: begin
                mul_a = K_TS_L;
                mul_b = vpv_r;
            end
            MULA: begin
                mul_a = K_TS_L;
                mul_b = vdiff;
            end
            default: ;
        endcase
    end

    // P&O: keep climbing while power does not drop, otherwise turn around.
    assign dir_next  = (mul_p >= p_prev) ? dir_up : ~dir_up;
    assign iref_step = dir_next ? sat_w(ext(iref) + ext(IREF_DELTA))
                                : sat_w(ext(iref) - ext(IREF_DELTA));
    assign iref_mppt = mode_r ? clamp_iref(iref_ext_r) : clamp_iref(iref_step);

    // Per-phase prediction: reference split evenly across the phases.
    assign iref_ph = iref >>> LOG2N;
    assign iph_cur = iph_r[int'(ph_idx)*W +: W];
    assign pred1   = sat_w(ext(iph_cur) + ext(kv1));
    assign pred0   = sat_w(ext(iph_cur) + ext(kv0));
    assign e1      = abs_w(sat_w(ext(iref_ph) - ext(pred1)));
    assign e0      = abs_w(sat_w(ext(iref_ph) - ext(pred0)));

    // Disabled phases stay off; on a tie the present switch state is kept.
    always_comb begin
        sw_bit = o_switch[ph_idx];
        if (!ph_en_r[ph_idx])
            sw_bit = 1'b0;
        else if (e1 < e0)
            sw_bit = 1'b1;
        else if (e0 < e1)
            sw_bit = 1'b0;
    end

    // Capture the step inputs on the accepted strobe; data only, no reset.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_calc_DV) begin
            vpv_r      <= i_Vpv;
            ipv_r      <= i_Ipv;
            vout_r     <= i_Vout;
            iref_ext_r <= i_Iref_ext;
            iph_r      <= i_Iph;
            ph_en_r    <= i_ph_en;
            mode_r     <= i_mode;
        end
    end

    // Step sequencer with registered status outputs and controller state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            ph_idx    <= '0;
            o_switch  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
            iref      <= IREF_INIT;
            p_prev    <= '0;
            dir_up    <= 1'b1;
            kv1       <= '0;
            kv0       <= '0;
            sw_nxt    <= '0;
        end else begin
            o_done    <= 1'b0;
            o_overrun <= (state != IDLE) && i_calc_DV;
            case (state)
                IDLE: begin
                    if (i_calc_DV) begin
                        o_busy <= 1'b1;
                        state  <= POWER;
                    end
                end
                POWER: begin
                    state <= MPPT;
                end
                MPPT: begin
                    iref   <= iref_mppt;
                    p_prev <= mul_p;
                    if (!mode_r)
                        dir_up <= dir_next;
                    state  <= MULA;
                end
                MULA: begin
                    kv1   <= mul_p;
                    state <= MULB;
                end
                MULB: begin
                    kv0    <= mul_p;
                    ph_idx <= '0;
                    state  <= EVAL;
                end
                EVAL: begin
                    sw_nxt[ph_idx] <= sw_bit;
                    if (ph_idx == PW'(N_PHASE - 1))
                        state <= UPDATE;
                    else
                        ph_idx <= ph_idx + 1'b1;
                end
                UPDATE: begin
                    o_switch <= sw_nxt;
                    o_done   <= 1'b1;
                    o_busy   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_Iref = iref;

endmodule

// File: tb/tb_mpc_multiphase.sv
// Directed bench for mpc_multiphase (W=32, F=16, N_PHASE=2).
module tb_mpc_multiphase;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic signed [31:0] i_Vpv;
    logic signed [31:0] i_Ipv;
    logic signed [31:0] i_Vout;
    logic [63:0]        i_Iph;
    logic [1:0]         i_ph_en;
    logic               i_mode;
    logic signed [31:0] i_Iref_ext;
    logic               i_calc_DV;
    logic [1:0]         o_switch;
    logic               o_busy;
    logic               o_done;
    logic               o_overrun;
    logic signed [31:0] o_Iref;

    int total = 0;
    int bad   = 0;

    mpc_multiphase dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_Vpv      (i_Vpv),
        .i_Ipv      (i_Ipv),
        .i_Vout     (i_Vout),
        .i_Iph      (i_Iph),
        .i_ph_en    (i_ph_en),
        .i_mode     (i_mode),
        .i_Iref_ext (i_Iref_ext),
        .i_calc_DV  (i_calc_DV),
        .o_switch   (o_switch),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overrun  (o_overrun),
        .o_Iref     (o_Iref)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic signed [31:0] qv(input int x);
        return 32'(x) <<< 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // One strobe, then twelve edges observed. ovr_at/rst_at place an extra
    // strobe or a reset just before that edge number (-1 = none).
    task automatic run_step(input logic signed [31:0] vpv, input logic signed [31:0] ipv,
                            input logic signed [31:0] vout, input logic signed [31:0] iph0,
                            input logic signed [31:0] iph1, input logic [1:0] en,
                            input logic mode, input logic signed [31:0] ext,
                            input int ovr_at, input int rst_at);
        int done_at;
        done_at = -1;
        @(negedge i_clk);
        i_Vpv      = vpv;
        i_Ipv      = ipv;
        i_Vout     = vout;
        i_Iph      = {iph1, iph0};
        i_ph_en    = en;
        i_mode     = mode;
        i_Iref_ext = ext;
        i_calc_DV  = 1'b1;
        @(posedge i_clk);
        #1;
        chk("busy_e0", 32'(o_busy), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            i_calc_DV = (k == ovr_at);
            i_reset   = (k == rst_at);
            @(posedge i_clk);
            #1;
            if (o_done && done_at < 0)
                done_at = k;
            if (ovr_at > 0 && k == ovr_at)
                chk("ovr_pulse", 32'(o_overrun), 32'd1);
            if (ovr_at > 0 && k == ovr_at + 1)
                chk("ovr_clear", 32'(o_overrun), 32'd0);
            if (rst_at > 0 && k == rst_at) begin
                chk("rst_busy", 32'(o_busy), 32'd0);
                chk("rst_sw", 32'(o_switch), 32'd0);
                chk("rst_iref", 32'(o_Iref), 32'(qv(4)));
            end
            if (rst_at < 0 && k == 6)
                chk("busy_e6", 32'(o_busy), 32'd1);
            if (rst_at < 0 && k == 7)
                chk("busy_e7", 32'(o_busy), 32'd0);
            if (rst_at < 0 && k == 8)
                chk("done_1cyc", 32'(o_done), 32'd0);
        end
        i_calc_DV = 1'b0;
        i_reset   = 1'b0;
        if (rst_at > 0)
            chk("no_done", 32'(done_at), 32'hFFFF_FFFF);
        else
            chk("done_edge", 32'(done_at), 32'd7);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_Vpv      = '0;
        i_Ipv      = '0;
        i_Vout     = '0;
        i_Iph      = '0;
        i_ph_en    = 2'b11;
        i_mode     = 1'b0;
        i_Iref_ext = '0;
        i_calc_DV  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_sw", 32'(o_switch), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_ovr", 32'(o_overrun), 32'd0);
        chk("reset_iref", 32'(o_Iref), 32'h0004_0000);
        @(negedge i_clk);
        i_reset = 1'b0;

        // P&O: P = 60, 80, 40 -> +, +, reverse
        run_step(qv(20), qv(3), qv(100), qv(0), qv(0), 2'b11, 1'b0, qv(0), -1, -1);
        chk("po_step1", 32'(o_Iref), 32'h0004_8000);
        run_step(qv(20), qv(4), qv(100), qv(0), qv(0), 2'b11, 1'b0, qv(0), -1, -1);
        chk("po_step2", 32'(o_Iref), 32'h0005_0000);
        run_step(qv(20), qv(2), qv(100), qv(0), qv(0), 2'b11, 1'b0, qv(0), -1, -1);
        chk("po_step3", 32'(o_Iref), 32'h0004_8000);

        // External reference 8: phase0 (Iph 0) -> 1, phase1 (Iph 30) -> 0
        do_reset();
        run_step(qv(20), qv(1), qv(100), qv(0), qv(30), 2'b11, 1'b1, qv(8), -1, -1);
        chk("ext_sw", 32'(o_switch), 32'h1);
        chk("ext_iref", 32'(o_Iref), 32'h0008_0000);

        // Tie on phase0 (e1 = e0 = 12.5) holds the prior bit, 1 then 0
        run_step(qv(20), qv(1), qv(100), qv(10), qv(30), 2'b11, 1'b1, qv(5), -1, -1);
        chk("tie_hold1", 32'(o_switch), 32'h1);
        run_step(qv(20), qv(1), qv(100), qv(30), qv(30), 2'b11, 1'b1, qv(8), -1, -1);
        chk("pre_tie0", 32'(o_switch), 32'h0);
        run_step(qv(20), qv(1), qv(100), qv(10), qv(30), 2'b11, 1'b1, qv(5), -1, -1);
        chk("tie_hold0", 32'(o_switch), 32'h0);

        // Disabled phase0 is forced off
        run_step(qv(20), qv(1), qv(100), qv(0), qv(30), 2'b11, 1'b1, qv(8), -1, -1);
        chk("en_pre", 32'(o_switch), 32'h1);
        run_step(qv(20), qv(1), qv(100), qv(0), qv(30), 2'b10, 1'b1, qv(8), -1, -1);
        chk("en_forced", 32'(o_switch), 32'h0);

        // Extra strobe sampled at edge 3 is dropped
        run_step(qv(20), qv(1), qv(100), qv(0), qv(30), 2'b11, 1'b1, qv(8), 3, -1);
        chk("ovr_sw", 32'(o_switch), 32'h1);

        // Reset at edge 4 aborts the step
        run_step(qv(20), qv(1), qv(100), qv(0), qv(30), 2'b11, 1'b1, qv(8), -1, 4);
        chk("abort_sw", 32'(o_switch), 32'h0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_iref", 32'(o_Iref), 32'h0004_0000);

        // Saturated power: 30000*30000 clips to max, so P=60 next is a drop
        run_step(qv(30000), qv(30000), qv(100), qv(0), qv(0), 2'b11, 1'b0, qv(0), -1, -1);
        chk("psat_up", 32'(o_Iref), 32'h0004_8000);
        run_step(qv(20), qv(3), qv(100), qv(0), qv(0), 2'b11, 1'b0, qv(0), -1, -1);
        chk("psat_rev", 32'(o_Iref), 32'h0004_0000);

        // Reference clamps
        run_step(qv(20), qv(1), qv(100), qv(0), qv(0), 2'b11, 1'b1, qv(100), -1, -1);
        chk("iref_max", 32'(o_Iref), 32'h0010_0000);
        run_step(qv(20), qv(1), qv(100), qv(0), qv(0), 2'b11, 1'b1, qv(-3), -1, -1);
        chk("iref_min", 32'(o_Iref), 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpc_multiphase.md
MPC_MULTIPHASE -- requirements
Module: mpc_multiphase

Interface
REQ-001 SHALL have parameter W, default 32: signed fixed-point word width.
REQ-002 SHALL have parameter F, default 16: fraction bits (Q(W-F).F).
REQ-003 SHALL have parameter N_PHASE, default 2: interleaved boost phases, power of 2, range 1..8.
REQ-004 SHALL have parameters K_TS_L (Ts/L, default 0.25), IREF_INIT (default 4.0), IREF_DELTA (default 0.5) and IREF_MAX (default 16.0), all Q-format.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_Vpv, i_Ipv, i_Vout  in  W each  PV voltage, PV current and output voltage, signed Q.
REQ-008 i_Iph  in  N_PHASE*W  per-phase inductor current; phase p occupies bits [p*W +: W].
REQ-009 i_ph_en  in  N_PHASE  phase enable mask.
REQ-010 i_mode  in  1  0 = P&O MPPT reference; 1 = external reference.
REQ-011 i_Iref_ext  in  W  external total current reference.
REQ-012 i_calc_DV  in  1  sample strobe that starts one control step.
REQ-013 o_switch  out  N_PHASE  gate command per phase.
REQ-014 o_busy, o_done, o_overrun  out  1 each  step in progress; step-complete pulse; strobe-lost pulse.
REQ-015 o_Iref  out  W  current total reference.

Function
REQ-016 FSM states SHALL be IDLE, POWER, MPPT, MULA, MULB, EVAL (N_PHASE cycles, phase index 0..N_PHASE-1), UPDATE.
REQ-017 In IDLE, i_calc_DV=1 SHALL register all data inputs and move to POWER at that edge (edge 0).
REQ-018 POWER SHALL compute P = Vpv*Ipv in the shared multiplier.
REQ-019 MPPT, mode 0: P >= P_prev keeps direction, else direction reverses; then Iref += dir*IREF_DELTA, clamped to [0, IREF_MAX].
REQ-020 MPPT, mode 1: Iref <= i_Iref_ext clamped to [0, IREF_MAX], direction unchanged.
REQ-021 MPPT SHALL update P_prev <= P in both modes.
REQ-022 MULA SHALL register KV1 = K_TS_L*Vpv.
REQ-023 MULB SHALL register KV0 = K_TS_L*(Vpv - Vout).
REQ-024 EVAL phase p: Iref_ph = Iref >>> log2(N_PHASE); e1 = |Iref_ph - (Iph_p + KV1)|; e0 = |Iref_ph - (Iph_p + KV0)|.
REQ-025 EVAL next state: 1 if e1 < e0; 0 if e0 < e1; phase's current o_switch bit if e1 == e0; forced 0 if i_ph_en[p]=0.
REQ-026 UPDATE SHALL load all o_switch bits simultaneously at edge N_PHASE+5 and pulse o_done for one cycle; IDLE follows.
REQ-027 o_switch SHALL hold its value between updates.
REQ-028 o_busy SHALL be 1 from edge 0 until the UPDATE exit edge.
REQ-029 i_calc_DV outside IDLE SHALL be ignored and SHALL pulse o_overrun for one cycle; a strobe coinciding with the UPDATE exit is also lost.
REQ-030 Products SHALL be full 2W-bit, then take bits [W+F-1:F] saturated to the signed W range.
REQ-031 Sums and differences SHALL be computed at W+1 bits and saturated to W bits.
REQ-032 Absolute value of the most-negative code SHALL saturate to max positive.

Reset
REQ-033 i_reset SHALL immediately force: state IDLE, o_switch 0, o_busy/o_done/o_overrun 0, Iref = o_Iref = IREF_INIT, P_prev 0, direction +1, KV1/KV0 0.
REQ-034 Reset mid-step SHALL abort the step with no partial o_switch update.

Structure
REQ-035 Package mpc_pkg SHALL hold the FSM state encoding, the Q-format saturation/abs functions and the default parameter constants.
REQ-036 One sub-module, mpc_sat_mul (registered signed W x W multiply with Q realign and saturation), SHALL be shared by POWER, MULA and MULB.

Verification
REQ-037 N=2, mode 0, i_ph_en=11. Strobes with Vpv=20, Vout=100, Ipv=3, then 4, then 2 -> o_Iref 4.5, 5.0, 4.5.
REQ-038 Mode 1, Iref_ext=8, Vpv=20, Vout=100, Iph={0,30} -> o_switch = 2'b01 (phase0=1, phase1=0); o_done exactly at edge 7 after the strobe.
REQ-039 Tie case: Iref_ext=5, Iph0=10, prior bit 1 -> o_switch[0] stays 1; with prior bit 0 -> stays 0.
REQ-040 i_ph_en=10 with REQ-038 stimulus -> o_switch[0]=0.
REQ-041 Second strobe at edge 3 -> o_overrun pulses; result and latency unchanged. Reset asserted at edge 4 -> all outputs at reset values, no o_done.
REQ-042 Saturation: Vpv=Ipv=30000 -> P saturates to max positive; Iref_ext=100 -> o_Iref=16.0.
